// File: rtl/display_resultado_if.sv
// ---------------------------------------------------------------------------
// display_resultado_if
// Signal bundle between the divider side (master) and the display stage
// (slave).
//
// Handshake: done is a single-cycle valid strobe with no ready. The
// display samples cociente/resto on any edge where done=1, it is idle, and
// clear=0. While busy=1, done pulses are dropped, not queued. clear=1 blanks
// the display and aborts any conversion. It also wins over a simultaneous
// done.
//
// Signals:
//   done       master->slave  result-valid pulse
//   cociente   master->slave  quotient 0..15
//   resto      master->slave  remainder 0..15
//   clear      master->slave  synchronous blank request
//   anodo      slave->master  one-hot digit enables
//   seg        slave->master  segments {g,f,e,d,c,b,a}
//   valid      slave->master  a converted result is on display
//   busy       slave->master  conversion in progress
//   state_dbg  slave->master  FSM state (0=IDLE, 1=CONV, 2=UPDATE)
// ---------------------------------------------------------------------------
interface display_resultado_if;
   logic       done;
   logic [3:0] cociente;
   logic [3:0] resto;
   logic       clear;
   logic [3:0] anodo;
   logic [6:0] seg;
   logic       valid;
   logic       busy;
   logic [1:0] state_dbg;

   modport master (
      output done, cociente, resto, clear,
      input  anodo, seg, valid, busy, state_dbg
   );

   modport slave (
      input  done, cociente, resto, clear,
      output anodo, seg, valid, busy, state_dbg
   );
endinterface

// File: rtl/display_resultado.sv
// ---------------------------------------------------------------------------
// display_resultado
// Captures the divider result on done and converts quotient and remainder
// to BCD with a 4-step shift-add-3 engine. It then drives a 4-digit
// multiplexed 7-segment display: the left pair shows Q, the right pair
// shows R.
//
// Ports:
//   clk  system clock
//   rst  synchronous reset, active-low
//   bus  display_resultado_if.slave (done/cociente/resto/clear in;
//        anodo/seg/valid/busy/state_dbg out)
// Parameters:
//   SCAN_DIV    prescaler width; one digit per 2^SCAN_DIV clocks
//   ACTIVE_LOW  1 = anodo/seg active-low, 0 = active-high
// ---------------------------------------------------------------------------
module display_resultado #(
   parameter int SCAN_DIV   = 16,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input logic                 clk,
   input logic                 rst,
   display_resultado_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONV   = 2'd1,
      UPDATE = 2'd2
   } state_t;

   // Digit code that renders as all segments off.
   localparam logic [3:0] BLANK = 4'hF;

   state_t                state_q, state_d;
   logic [2:0]            step_q, step_d;
   logic [3:0]            q_sr_q, q_sr_d, r_sr_q, r_sr_d;
   logic [4:0]            q_acc_q, q_acc_d, r_acc_q, r_acc_d;
   logic [3:0][3:0]       dig_q, dig_d;   // [3]=Q tens .. [0]=R units
   logic                  valid_q, valid_d;
   logic                  busy_q, busy_d;
   logic [SCAN_DIV-1:0]   presc_q, presc_d;
   logic [1:0]            idx_q, idx_d;
   logic [3:0]            anodo_q, anodo_d;
   logic [6:0]            seg_q, seg_d;

   // One double-dabble step on a {tens, units} accumulator: correct
   // units >= 5 by adding 3, then shift in the operand MSB.
   function automatic logic [4:0] dd_step(input logic [4:0] acc,
                                          input logic [3:0] sr);
      logic [3:0] units;
      units = acc[3:0];
      if (units >= 4'd5) units = units + 4'd3;
      return {units, sr[3]};
   endfunction

   // Active-low segment pattern for one digit code.
   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      q_sr_d  = q_sr_q;
      r_sr_d  = r_sr_q;
      q_acc_d = q_acc_q;
      r_acc_d = r_acc_q;
      dig_d   = dig_q;
      valid_d = valid_q;
      busy_d  = busy_q;

      case (state_q)
         IDLE: begin
            if (bus.done && !bus.clear) begin
               q_sr_d  = bus.cociente;
               r_sr_d  = bus.resto;
               q_acc_d = '0;
               r_acc_d = '0;
               step_d  = '0;
               busy_d  = 1'b1;
               state_d = CONV;
            end
         end
         CONV: begin
            q_acc_d = dd_step(q_acc_q, q_sr_q);
            r_acc_d = dd_step(r_acc_q, r_sr_q);
            q_sr_d  = {q_sr_q[2:0], 1'b0};
            r_sr_d  = {r_sr_q[2:0], 1'b0};
            step_d  = step_q + 3'd1;
            if (step_q == 3'd3) state_d = UPDATE;
         end
         UPDATE: begin
            // A 4-bit operand has a tens digit of either 0 (blanked) or 1.
            dig_d[3] = q_acc_q[4] ? 4'd1 : BLANK;
            dig_d[2] = q_acc_q[3:0];
            dig_d[1] = r_acc_q[4] ? 4'd1 : BLANK;
            dig_d[0] = r_acc_q[3:0];
            valid_d  = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // clear overrides the FSM, including a done in the same cycle.
      if (bus.clear) begin
         state_d = IDLE;
         busy_d  = 1'b0;
         valid_d = 1'b0;
         dig_d   = {4{BLANK}};
      end
   end

   // Scan runs continuously. The output registers follow the index by one
   // cycle, and index 0 maps to the leftmost digit (anodo[3]).
   always_comb begin
      presc_d = presc_q + SCAN_DIV'(1);
      idx_d   = idx_q;
      if (presc_q == '1) idx_d = idx_q + 2'd1;
      anodo_d = (4'b1000 >> idx_q) ^ {4{ACTIVE_LOW}};
      seg_d   = (valid_q ? seg_of(dig_q[~idx_q]) : 7'h7F) ^ {7{~ACTIVE_LOW}};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         step_q  <= '0;
         q_sr_q  <= '0;
         r_sr_q  <= '0;
         q_acc_q <= '0;
         r_acc_q <= '0;
         dig_q   <= {4{BLANK}};
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         presc_q <= '0;
         idx_q   <= '0;
         anodo_q <= {4{ACTIVE_LOW}};
         seg_q   <= {7{ACTIVE_LOW}};
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         q_sr_q  <= q_sr_d;
         r_sr_q  <= r_sr_d;
         q_acc_q <= q_acc_d;
         r_acc_q <= r_acc_d;
         dig_q   <= dig_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         presc_q <= presc_d;
         idx_q   <= idx_d;
         anodo_q <= anodo_d;
         seg_q   <= seg_d;
      end
   end

   assign bus.anodo     = anodo_q;
   assign bus.seg       = seg_q;
   assign bus.valid     = valid_q;
   assign bus.busy      = busy_q;
   assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_display_resultado.sv
// ---------------------------------------------------------------------------
// tb_display_resultado
// Bench for display_resultado with SCAN_DIV=2 and ACTIVE_LOW=1. Inputs are
// driven and outputs sampled on the falling edge. The expected digit
// patterns come from a /10 and %10 reference and the segment table.
// ---------------------------------------------------------------------------
module tb_display_resultado;
   localparam int SCAN_DIV = 2;
   localparam int DWELL    = 1 << SCAN_DIV;
   localparam logic [6:0] BL = 7'h7F;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   display_resultado_if dif ();

   display_resultado #(
      .SCAN_DIV   (SCAN_DIV),
      .ACTIVE_LOW (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (dif)
   );

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [27:0] exp_q[$];
   logic [6:0]  seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   typedef struct {
      int          q;
      int          r;
      logic [27:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference display word {Q tens, Q units, R tens, R units}.
   function automatic logic [6:0] digit_pat(input int v, input bit is_tens);
      if (is_tens && v == 0) return BL;
      return seg_tab[v];
   endfunction

   function automatic logic [27:0] model(input int q, input int r);
      return {digit_pat(q / 10, 1'b1), digit_pat(q % 10, 1'b0),
              digit_pat(r / 10, 1'b1), digit_pat(r % 10, 1'b0)};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic start(input int q, input int r);
      dif.done     = 1'b1;
      dif.cociente = 4'(q);
      dif.resto    = 4'(r);
      tick();
      dif.done     = 1'b0;
   endtask

   task automatic wait_not_busy(input string name);
      int n = 0;
      while (dif.busy && n < 12) begin
         tick();
         n++;
      end
      check({name, "_busy_end"}, 32'(dif.busy), 32'd0);
      check({name, "_valid"}, 32'(dif.valid), 32'd1);
   endtask

   // Watches one full scan and assembles the four displayed patterns.
   task automatic capture(input string name, output logic [27:0] word);
      logic [3:0] seen;
      seen = '0;
      word = '0;
      for (int i = 0; i < 8 * DWELL && seen != 4'hF; i++) begin
         tick();
         case (dif.anodo)
            4'h7: begin word[27:21] = dif.seg; seen[3] = 1'b1; end
            4'hB: begin word[20:14] = dif.seg; seen[2] = 1'b1; end
            4'hD: begin word[13:7]  = dif.seg; seen[1] = 1'b1; end
            4'hE: begin word[6:0]   = dif.seg; seen[0] = 1'b1; end
            default: ;
         endcase
      end
      check({name, "_scan_all"}, 32'(seen), 32'hF);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      vec_t        vecs[6];
      logic [3:0]  an_seq[4];
      logic [27:0] w;
      int          order[256];
      string       nm;

      dif.done = 1'b0; dif.clear = 1'b0; dif.cociente = '0; dif.resto = '0;
      vecs[0] = '{13, 2,  {7'h79, 7'h30, 7'h7F, 7'h24}};
      vecs[1] = '{0,  0,  {7'h7F, 7'h40, 7'h7F, 7'h40}};
      vecs[2] = '{15, 14, {7'h79, 7'h12, 7'h79, 7'h19}};
      vecs[3] = '{10, 10, {7'h79, 7'h40, 7'h79, 7'h40}};
      vecs[4] = '{7,  12, {7'h7F, 7'h78, 7'h79, 7'h24}};
      vecs[5] = '{9,  5,  {7'h7F, 7'h10, 7'h7F, 7'h12}};
      an_seq  = '{4'h7, 4'hB, 4'hD, 4'hE};

      // Reset held for 3 cycles.
      repeat (3) tick();
      check("rst_anodo", 32'(dif.anodo), 32'hF);
      check("rst_seg",   32'(dif.seg),   32'h7F);
      check("rst_valid", 32'(dif.valid), 32'd0);
      check("rst_busy",  32'(dif.busy),  32'd0);
      check("rst_state", 32'(dif.state_dbg), 32'd0);
      rst = 1'b1;
      for (int i = 0; i < 4 * DWELL; i++) begin
         tick();
         check($sformatf("scan_anodo_%0d", i), 32'(dif.anodo),
               32'(an_seq[i / DWELL]));
         check($sformatf("scan_seg_%0d", i), 32'(dif.seg), 32'h7F);
      end

      // Directed vectors with exact busy/valid latency.
      foreach (vecs[v]) begin
         nm = $sformatf("vec_q%0d_r%0d", vecs[v].q, vecs[v].r);
         start(vecs[v].q, vecs[v].r);
         for (int i = 0; i < 5; i++) begin
            check($sformatf("%s_busy_k%0d", nm, i), 32'(dif.busy), 32'd1);
            tick();
         end
         check({nm, "_busy_k5"},  32'(dif.busy),  32'd0);
         check({nm, "_valid_k5"}, 32'(dif.valid), 32'd1);
         capture(nm, w);
         check({nm, "_digits"}, 32'(w), 32'(vecs[v].exp));
      end

      // Second done while busy is ignored: 9/5 stays on display.
      start(1, 1);
      wait_not_busy("pre_ignore");
      start(9, 5);
      tick();
      start(1, 1);
      wait_not_busy("ignore");
      capture("ignore", w);
      check("ignore_digits", 32'(w), 32'(model(9, 5)));
      check("ignore_no_restart", 32'(dif.busy), 32'd0);
      check("ignore_state", 32'(dif.state_dbg), 32'd0);

      // clear together with done: blank, no conversion.
      dif.clear = 1'b1; dif.done = 1'b1; dif.cociente = 4'd3; dif.resto = 4'd3;
      tick();
      dif.clear = 1'b0; dif.done = 1'b0;
      check("clr_valid", 32'(dif.valid), 32'd0);
      check("clr_busy",  32'(dif.busy),  32'd0);
      check("clr_state", 32'(dif.state_dbg), 32'd0);
      capture("clr", w);
      check("clr_digits", 32'(w), 32'({4{BL}}));
      check("clr_busy_after", 32'(dif.busy), 32'd0);

      // Reset in the middle of a conversion.
      start(12, 7);
      tick();
      rst = 1'b0;
      tick();
      check("mid_rst_busy",  32'(dif.busy),  32'd0);
      check("mid_rst_valid", 32'(dif.valid), 32'd0);
      check("mid_rst_state", 32'(dif.state_dbg), 32'd0);
      rst = 1'b1;
      tick();
      start(15, 14);
      wait_not_busy("post_rst");
      capture("post_rst", w);
      check("post_rst_digits", 32'(w), 32'({7'h79, 7'h12, 7'h79, 7'h19}));

      // Full Q/R sweep in random order against the reference model.
      for (int i = 0; i < 256; i++) order[i] = i;
      for (int i = 255; i > 0; i--) begin
         int j, t;
         j = int'($urandom_range(0, i));
         t = order[i]; order[i] = order[j]; order[j] = t;
      end
      for (int i = 0; i < 256; i++) begin
         int q, r;
         q = order[i] >> 4;
         r = order[i] & 15;
         repeat ($urandom_range(0, 2)) tick();
         nm = $sformatf("sweep_q%0d_r%0d", q, r);
         exp_q.push_back(model(q, r));
         start(q, r);
         wait_not_busy(nm);
         capture(nm, w);
         check({nm, "_digits"}, 32'(w), 32'(exp_q.pop_front()));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/display_resultado.md
Name: display_resultado

Overview:
Downstream stage of the 4-bit divider (`operacion`). On the divider's `done` pulse it captures `cociente` and `resto`, converts each to two decimal digits with a sequential shift-add-3 (double-dabble) engine, and drives a 4-digit multiplexed 7-segment display. Left pair shows the quotient, right pair shows the remainder.

Parameters:
- SCAN_DIV, 16: prescaler width; the display advances one digit every 2^SCAN_DIV clocks.
- ACTIVE_LOW, 1: 1 means `anodo` and `seg` are active-low; 0 means active-high.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- done  in  1  result-valid pulse from the divider
- cociente  in  4  quotient 0..15, sampled when `done`=1
- resto  in  4  remainder 0..15, sampled when `done`=1
- clear  in  1  synchronous blank request
- anodo  out  4  digit enables, one-hot; [3]=Q tens, [2]=Q units, [1]=R tens, [0]=R units
- seg  out  7  segments {g,f,e,d,c,b,a}
- valid  out  1  a converted result is on display
- busy  out  1  conversion in progress

Behaviour:
- All state and outputs are registered and update on the rising edge of clk.
- Reset (rst=0 at an edge):
  - FSM goes to IDLE; prescaler and digit index are 0; digit registers are cleared.
  - `valid`=0, `busy`=0.
  - `anodo` = all inactive (4'hF when ACTIVE_LOW=1).
  - `seg` = all off (7'h7F when ACTIVE_LOW=1).
  - Reset overrides everything, including mid-conversion.
- FSM states: IDLE, CONV, UPDATE.
  - IDLE: if `done`=1 and `clear`=0, latch `cociente` and `resto`, zero both BCD accumulators, set step counter to 0, go to CONV, set `busy`=1.
  - CONV: one double-dabble step per cycle on both operands in parallel.
    - Per operand: 5-bit BCD accumulator ({tens bit, units nibble}) plus 4-bit shift register.
    - Each step: if units ≥ 5, add 3 to units; then shift left one bit, MSB of the operand entering units bit 0.
    - Exactly 4 steps, then go to UPDATE.
  - UPDATE: write the four display digit registers, set `valid`=1, clear `busy`, return to IDLE.
- Latency: `done` sampled at edge k gives `busy`=1 after edges k..k+4 and new digits plus `valid`=1 after edge k+5.
- `done` while `busy`=1 is ignored. Results are not queued.
- `clear`=1 (with rst=1):
  - At the next edge: `valid`=0, all digits blank, FSM aborts to IDLE, `busy`=0.
  - `clear` beats a simultaneous `done`, which is dropped.
- Digit rules:
  - A tens digit of 0 is blanked (segments off).
  - A units digit always shows, including '0'.
  - When `valid`=0, all four digits are blanked.
- Scan:
  - Prescaler counts every cycle from reset release.
  - On wrap (all ones → 0), the digit index advances 0→1→2→3→0.
  - Outputs are registered one cycle after the index: `anodo` enables the selected digit and `seg` carries its pattern.
  - Index 0 selects `anodo[3]`, index 3 selects `anodo[0]`.
  - Scanning continues regardless of FSM state.
  - Display registers change only in UPDATE or on `clear`/reset, so no partial result is ever shown.
- Segment encoding: standard 0-9 with ACTIVE_LOW=1. Values: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, blank=7'h7F. ACTIVE_LOW=0 inverts all of these.

Test Plan (SCAN_DIV=2, ACTIVE_LOW=1):
- Reset: hold rst=0 for 3 cycles → `anodo`=4'hF, `seg`=7'h7F, `valid`=0, `busy`=0. Release → scan advances every 4 cycles through anodo 4'h7, 4'hB, 4'hD, 4'hE with `seg`=7'h7F.
- `done` with Q=13, R=2 → `busy`=1 for 5 cycles, `valid`=1 at k+5. Displayed: Q tens=7'h79 ("1"), Q units=7'h30 ("3"), R tens=7'h7F (blank), R units=7'h24 ("2").
- `done` with Q=0, R=0 → both units digits 7'h40, both tens digits 7'h7F. Then sweep all 16×16 Q/R pairs and compare the four digits to the /10 and %10 reference.
- `done` with Q=9, R=5, then a second `done` with Q=1, R=1 two cycles later while busy → display shows 9/5 and the second pulse is ignored.
- `clear` and `done` asserted in the same cycle while showing 9/5 → `valid`=0, all `seg`=7'h7F, `busy`=0, no conversion starts.
- rst=0 at k+2 of a conversion → `busy`=0, `valid`=0, and the FSM is in IDLE. A following `done` with Q=15, R=14 converts correctly to "1","5","1","4".
